// File: rtl/gpu_arb_pkg.sv
// gpu_arb_pkg: shared types and constants for the GPU host-port arbiter.
//   arb_state_e  - arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   REQ_HOST     - requester index of the Z80 host bus bridge
//   REQ_GEO      - requester index of the geometry/blitter engine
//   OOR_RDATA    - byte returned by a read whose address is out of range
package gpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic       REQ_HOST  = 1'b0;
  localparam logic       REQ_GEO   = 1'b1;
  localparam logic [7:0] OOR_RDATA = 8'hFF;

endpackage

// File: rtl/gpu_arb_pick2.sv
// gpu_arb_pick2: combinational two-way request picker.
//   req_0_i, req_1_i - pending requests
//   ptr_i            - favoured requester on a tie (round-robin build only)
//   win_o            - index of the chosen requester
//   vld_o            - at least one request is pending
// Build option GPU_HOST_ARB_ROUND_ROBIN_EN selects round-robin on ties;
// without it requester 0 always wins and ptr_i is ignored.
module gpu_arb_pick2
  import gpu_arb_pkg::*;
(
  input  logic req_0_i,
  input  logic req_1_i,
  input  logic ptr_i,
  output logic win_o,
  output logic vld_o
);

  assign vld_o = req_0_i | req_1_i;

`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
  always_comb begin
    win_o = REQ_HOST;
    if (req_0_i && req_1_i) win_o = ptr_i;
    else if (req_1_i)       win_o = REQ_GEO;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;
  assign win_o      = req_0_i ? REQ_HOST : REQ_GEO;
`endif

endmodule

// File: rtl/gpu_host_port_arbiter.sv
// gpu_host_port_arbiter: shares RAM port B between the Z80 host bridge
// (requester 0) and the geometry/blitter engine (requester 1).
// Serialises byte reads/writes with a req/ack handshake, hides the RAM read
// latency and range-checks addresses against the implemented RAM size.
//   clk, rst                 - clock, asynchronous active-high reset
//   req_n/wr_n/addr_n/wdata_n - request channel of requester n
//   ack_0, ack_1             - one-cycle completion pulses
//   rdata, ack_err           - read data (held until next ack), range error
//   busy                     - arbiter not in IDLE
//   ram_addr/ram_wdata/ram_we/ram_rdata - RAM port B
// Build option GPU_HOST_ARB_ROUND_ROBIN_EN: round-robin on simultaneous
// requests; otherwise fixed priority to requester 0.
// Every output is a flop; inputs only reach next-state logic.
module gpu_host_port_arbiter
  import gpu_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 14,
  parameter int RAM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_0,
  input  logic        wr_0,
  input  logic [19:0] addr_0,
  input  logic [7:0]  wdata_0,
  input  logic        req_1,
  input  logic        wr_1,
  input  logic [19:0] addr_1,
  input  logic [7:0]  wdata_1,
  output logic        ack_0,
  output logic        ack_1,
  output logic [7:0]  rdata,
  output logic        ack_err,
  output logic        busy,
  output logic [19:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  localparam int CNT_W = 3;

  arb_state_e       state_q, state_d;
  logic             win_q, win_d;
  logic             wr_q, wr_d;
  logic             inrng_q, inrng_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [19:0]      ram_addr_q, ram_addr_d;
  logic [7:0]       ram_wdata_q, ram_wdata_d;
  logic             ram_we_q, ram_we_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             busy_q, busy_d;

  logic             pick_ptr, pick_win, pick_vld;
  logic             sel_wr, sel_inrng;
  logic [19:0]      sel_addr;
  logic [7:0]       sel_wdata;

`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
  // ptr names the requester favoured on the next tie
  logic ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = REQ_HOST;
`endif

  gpu_arb_pick2 u_pick (
    .req_0_i (req_0),
    .req_1_i (req_1),
    .ptr_i   (pick_ptr),
    .win_o   (pick_win),
    .vld_o   (pick_vld)
  );

  assign sel_wr    = pick_win ? wr_1    : wr_0;
  assign sel_addr  = pick_win ? addr_1  : addr_0;
  assign sel_wdata = pick_win ? wdata_1 : wdata_0;
  // In range when no bit at or above ADDR_SIZE is set
  assign sel_inrng = ((sel_addr >> ADDR_SIZE) == 20'd0);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    wr_d        = wr_q;
    inrng_d     = inrng_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d       = pick_win;
          wr_d        = sel_wr;
          inrng_d     = sel_inrng;
          ram_addr_d  = sel_addr;
          ram_wdata_d = sel_wdata;
          // out-of-range writes never reach the RAM
          ram_we_d    = sel_wr & sel_inrng;
          state_d     = ISSUE;
`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
          ptr_d       = ~pick_win;
`endif
        end
      end
      ISSUE: begin
        if (wr_q) begin
          ack0_d  = (win_q == REQ_HOST);
          ack1_d  = (win_q == REQ_GEO);
          err_d   = ~inrng_q;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RAM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d = inrng_q ? ram_rdata : OOR_RDATA;
          ack0_d  = (win_q == REQ_HOST);
          ack1_d  = (win_q == REQ_GEO);
          err_d   = ~inrng_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= REQ_HOST;
      wr_q        <= 1'b0;
      inrng_q     <= 1'b0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
      ptr_q       <= REQ_HOST;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      inrng_q     <= inrng_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ack_0     = ack0_q;
  assign ack_1     = ack1_q;
  assign ack_err   = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gpu_host_port_arbiter.sv
// Testbench for gpu_host_port_arbiter: scoreboard of expected completions,
// a 64-byte aliasing RAM model with RAM_LAT read latency, and one task per
// scenario. Works with or without GPU_HOST_ARB_ROUND_ROBIN_EN.
module tb_gpu_host_port_arbiter;

  localparam int ADDR_SIZE = 14;
  localparam int RAM_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_0 = 1'b0, wr_0 = 1'b0, req_1 = 1'b0, wr_1 = 1'b0;
  logic [19:0] addr_0 = '0, addr_1 = '0;
  logic [7:0]  wdata_0 = '0, wdata_1 = '0;
  logic        ack_0, ack_1, ack_err, busy, ram_we;
  logic [7:0]  rdata, ram_wdata, ram_rdata;
  logic [19:0] ram_addr;

  always #5 clk = ~clk;

  gpu_host_port_arbiter #(.ADDR_SIZE(ADDR_SIZE), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .wr_0(wr_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .wr_1(wr_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ack_0(ack_0), .ack_1(ack_1), .rdata(rdata), .ack_err(ack_err),
    .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // RAM model: 64 bytes aliased on addr[5:0]; unwritten bytes read as a
  // pattern of the low address byte.
  logic       mem_clr = 1'b1;
  logic [7:0] mem [0:63];
  logic       mv  [0:63];
  logic [7:0] dpipe [0:RAM_LAT-1];

  function automatic logic [7:0] pat(input logic [19:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_mem(input logic [19:0] a);
    return mv[a[5:0]] ? mem[a[5:0]] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mv[i] <= 1'b0;
    end else if (ram_we) begin
      mem[ram_addr[5:0]] <= ram_wdata;
      mv[ram_addr[5:0]]  <= 1'b1;
    end
    dpipe[0] <= rd_mem(ram_addr);
    for (int i = 1; i < RAM_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign ram_rdata = dpipe[RAM_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         who;
    int         lat;
    logic [7:0] rd;
    logic       err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic start_req(input int k, input logic w, input logic [19:0] a, input logic [7:0] d);
    if (k == 0) begin req_0 = 1'b1; wr_0 = w; addr_0 = a; wdata_0 = d; end
    else        begin req_1 = 1'b1; wr_1 = w; addr_1 = a; wdata_1 = d; end
  endtask

  // Drives one request and observes it; no checking here.
  // lat = cycles from E0 to ack (-1 on timeout).
  task automatic run_one(input int k, input logic w, input logic [19:0] a, input logic [7:0] d,
                         output int lat, output int wec, output logic [19:0] wa,
                         output logic [7:0] wd, output logic [7:0] rd, output logic er,
                         output logic oth);
    lat = -1; wec = 0; wa = '0; wd = '0; rd = '0; er = 1'b0; oth = 1'b0;
    @(negedge clk);
    start_req(k, w, a, d);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      #1;
      if (ram_we) begin wec++; wa = ram_addr; wd = ram_wdata; end
      if ((k == 0) ? ack_1 : ack_0) oth = 1'b1;
      if ((k == 0) ? ack_0 : ack_1) begin
        lat = n; rd = rdata; er = ack_err;
        break;
      end
      @(posedge clk);
    end
    if (k == 0) req_0 = 1'b0; else req_1 = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_addr, ram_wdata, ram_we, ack_0, ack_1, ack_err, rdata, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%h wd=%h we=%b a0=%b a1=%b err=%b rd=%h busy=%b, want all 0",
               ram_addr, ram_wdata, ram_we, ack_0, ack_1, ack_err, rdata, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
  endtask

  task automatic test_write();
    int lat, wec; logic [19:0] wa; logic [7:0] wd, rd; logic er, oth; exp_t e;
    sb.push_back('{who: 0, lat: 2, rd: 8'h00, err: 1'b0});
    run_one(0, 1'b1, 20'h00123, 8'hA5, lat, wec, wa, wd, rd, er, oth);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL wr_ack_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (wec !== 1) begin n_bad++; $display("FAIL wr_we_cycles: got %0d want 1", wec); end
    n_cmp++; if (wa !== 20'h00123) begin n_bad++; $display("FAIL wr_ram_addr: got %h want 00123", wa); end
    n_cmp++; if (wd !== 8'hA5) begin n_bad++; $display("FAIL wr_ram_wdata: got %h want a5", wd); end
    n_cmp++; if (er !== e.err || oth !== 1'b0) begin n_bad++; $display("FAIL wr_err_other: got err=%b other=%b want 0 0", er, oth); end
  endtask

  task automatic test_read();
    int lat, wec; logic [19:0] wa; logic [7:0] wd, rd; logic er, oth; exp_t e;
    run_one(0, 1'b1, 20'h00040, 8'h3C, lat, wec, wa, wd, rd, er, oth);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_setup_lat: got %0d want 2", lat); end
    sb.push_back('{who: 1, lat: RAM_LAT + 2, rd: 8'h3C, err: 1'b0});
    run_one(1, 1'b0, 20'h00040, 8'h00, lat, wec, wa, wd, rd, er, oth);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rd_ack_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rd) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, e.rd); end
    n_cmp++; if (er !== e.err || wec !== 0) begin n_bad++; $display("FAIL rd_err_we: got err=%b we=%0d want 0 0", er, wec); end
  endtask

  task automatic test_out_of_range();
    int lat, wec; logic [19:0] wa; logic [7:0] wd, rd; logic er, oth; exp_t e;
    sb.push_back('{who: 0, lat: 2, rd: 8'h00, err: 1'b1});
    run_one(0, 1'b1, 20'h04000, 8'h77, lat, wec, wa, wd, rd, er, oth);
    e = sb.pop_front();
    n_cmp++; if (wec !== 0) begin n_bad++; $display("FAIL oor_wr_we: got %0d cycles want 0", wec); end
    n_cmp++; if (lat !== e.lat || er !== e.err) begin n_bad++; $display("FAIL oor_wr_ack: got lat=%0d err=%b want %0d %b", lat, er, e.lat, e.err); end
    sb.push_back('{who: 1, lat: RAM_LAT + 2, rd: 8'hFF, err: 1'b1});
    run_one(1, 1'b0, 20'h04000, 8'h00, lat, wec, wa, wd, rd, er, oth);
    e = sb.pop_front();
    n_cmp++; if (rd !== e.rd || er !== e.err) begin n_bad++; $display("FAIL oor_rd: got rd=%h err=%b want %h %b", rd, er, e.rd, e.err); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL oor_rd_lat: got %0d want %0d", lat, e.lat); end
    // 0x00040 aliases the same model byte: must still hold the earlier write
    sb.push_back('{who: 1, lat: RAM_LAT + 2, rd: 8'h3C, err: 1'b0});
    run_one(1, 1'b0, 20'h00040, 8'h00, lat, wec, wa, wd, rd, er, oth);
    e = sb.pop_front();
    n_cmp++; if (rd !== e.rd || er !== e.err) begin n_bad++; $display("FAIL oor_no_write: got rd=%h err=%b want %h %b", rd, er, e.rd, e.err); end
  endtask

  task automatic test_contention();
    logic [19:0] a0 [0:1];
    logic [19:0] a1 [0:1];
    int i0, i1, done;
    exp_t e;
    a0[0] = 20'h00011; a0[1] = 20'h00012;
    a1[0] = 20'h00021; a1[1] = 20'h00022;
`ifdef GPU_HOST_ARB_ROUND_ROBIN_EN
    sb.push_back('{who: 0, lat: 0, rd: pat(a0[0]), err: 1'b0});
    sb.push_back('{who: 1, lat: 0, rd: pat(a1[0]), err: 1'b0});
    sb.push_back('{who: 0, lat: 0, rd: pat(a0[1]), err: 1'b0});
    sb.push_back('{who: 1, lat: 0, rd: pat(a1[1]), err: 1'b0});
`else
    sb.push_back('{who: 0, lat: 0, rd: pat(a0[0]), err: 1'b0});
    sb.push_back('{who: 0, lat: 0, rd: pat(a0[1]), err: 1'b0});
    sb.push_back('{who: 1, lat: 0, rd: pat(a1[0]), err: 1'b0});
    sb.push_back('{who: 1, lat: 0, rd: pat(a1[1]), err: 1'b0});
`endif
    i0 = 0; i1 = 0; done = 0;
    @(negedge clk);
    start_req(0, 1'b0, a0[0], 8'h00);
    start_req(1, 1'b0, a1[0], 8'h00);
    for (int n = 0; n < 200 && done < 4; n++) begin
      @(posedge clk); #1;
      if (ack_0 && ack_1) begin
        n_cmp++; n_bad++;
        $display("FAIL cont_dual_ack: got both acks want one");
      end
      if (ack_0 || ack_1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cont_extra_ack: got ack with empty scoreboard want none");
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if ((ack_1 ? 1 : 0) !== e.who || rdata !== e.rd || ack_err !== e.err) begin
            n_bad++;
            $display("FAIL cont_grant%0d: got who=%0d rd=%h err=%b want who=%0d rd=%h err=%b",
                     done, ack_1 ? 1 : 0, rdata, ack_err, e.who, e.rd, e.err);
          end
        end
        done++;
        if (ack_0) begin
          i0++;
          if (i0 < 2) addr_0 = a0[i0]; else req_0 = 1'b0;
        end else begin
          i1++;
          if (i1 < 2) addr_1 = a1[i1]; else req_1 = 1'b0;
        end
      end
    end
    n_cmp++;
    if (done !== 4) begin
      n_bad++;
      $display("FAIL cont_timeout: got %0d grants want 4", done);
    end
    req_0 = 1'b0; req_1 = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int i, last;
    exp_t e;
    // writes, requester 0 holding req
    for (int k = 0; k < 3; k++) sb.push_back('{who: 0, lat: 3, rd: 8'h00, err: 1'b0});
    i = 0; last = -1;
    @(negedge clk);
    start_req(0, 1'b1, 20'h00030, 8'h10);
    for (int n = 0; n < 100 && i < 3; n++) begin
      @(posedge clk); #1;
      if (ack_0) begin
        e = sb.pop_front();
        if (i > 0) begin
          n_cmp++;
          if ((cyc - last) !== e.lat || ack_err !== e.err) begin
            n_bad++;
            $display("FAIL b2b_wr_gap%0d: got gap=%0d err=%b want %0d %b", i, cyc - last, ack_err, e.lat, e.err);
          end
        end
        last = cyc; i++;
        if (i < 3) begin addr_0 = 20'h00030 + 20'(i); wdata_0 = 8'h10 + 8'(i); end
        else req_0 = 1'b0;
      end
    end
    n_cmp++; if (i !== 3) begin n_bad++; $display("FAIL b2b_wr_timeout: got %0d acks want 3", i); end
    req_0 = 1'b0; sb.delete();
    repeat (2) @(posedge clk);
    // read back, requester 1 holding req
    for (int k = 0; k < 3; k++) sb.push_back('{who: 1, lat: RAM_LAT + 3, rd: 8'h10 + 8'(k), err: 1'b0});
    i = 0; last = -1;
    @(negedge clk);
    start_req(1, 1'b0, 20'h00030, 8'h00);
    for (int n = 0; n < 100 && i < 3; n++) begin
      @(posedge clk); #1;
      if (ack_1) begin
        e = sb.pop_front();
        n_cmp++;
        if (rdata !== e.rd || (i > 0 && (cyc - last) !== e.lat)) begin
          n_bad++;
          $display("FAIL b2b_rd%0d: got rd=%h gap=%0d want rd=%h gap=%0d", i, rdata, cyc - last, e.rd, e.lat);
        end
        last = cyc; i++;
        if (i < 3) addr_1 = 20'h00030 + 20'(i); else req_1 = 1'b0;
      end
    end
    n_cmp++; if (i !== 3) begin n_bad++; $display("FAIL b2b_rd_timeout: got %0d acks want 3", i); end
    req_1 = 1'b0; sb.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_wait();
    int lat, wec; logic [19:0] wa; logic [7:0] wd, rd; logic er, oth, seen; exp_t e;
    // reset during ISSUE of a write: ram_we must drop without a clock edge
    @(negedge clk);
    start_req(0, 1'b1, 20'h00035, 8'h99);
    @(posedge clk); #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL rst_issue_we_pre: got %b want 1", ram_we); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ram_we !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_issue_async: got we=%b busy=%b want 0 0", ram_we, busy); end
    req_0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (mv[6'h35] !== 1'b0) begin n_bad++; $display("FAIL rst_issue_nowrite: got written=%b want 0", mv[6'h35]); end
    // reset during WAIT of a read
    @(negedge clk);
    start_req(1, 1'b0, 20'h00040, 8'h00);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ram_we, busy, ack_0, ack_1, ack_err, rdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_wait_state: got we=%b busy=%b a0=%b a1=%b err=%b rd=%h want all 0",
               ram_we, busy, ack_0, ack_1, ack_err, rdata);
    end
    req_1 = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (ack_0 || ack_1) seen = 1'b1; end
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack_0 || ack_1) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_wait_noack: got ack want none"); end
    // normal write after reset
    sb.push_back('{who: 0, lat: 2, rd: 8'h00, err: 1'b0});
    run_one(0, 1'b1, 20'h00036, 8'h5E, lat, wec, wa, wd, rd, er, oth);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || wec !== 1 || wa !== 20'h00036 || wd !== 8'h5E) begin
      n_bad++;
      $display("FAIL rst_post_write: got lat=%0d we=%0d addr=%h wd=%h want %0d 1 00036 5e", lat, wec, wa, wd, e.lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_write();
    test_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpu_host_port_arbiter.md
# gpu_host_port_arbiter

Shares the single host-side port (port B) of the multiport GPU RAM between two requesters: requester 0, the Z80 host bus bridge, and requester 1, the geometry/blitter engine. It sits between those requesters and the RAM's clk-domain host port. It serialises byte reads and writes with a req/ack handshake and hides the RAM read latency. It also range-checks addresses against the instantiated RAM size.

## Interface
Parameters:
- ADDR_SIZE, 14, implemented RAM address bits; addresses with any bit set in [19:ADDR_SIZE] are out of range
- RAM_LAT, 2, clk cycles from the port-B address edge to valid port-B read data; legal range 1..7

Ports:
- clk  in  1  GPU system clock; the single clock for the block
- rst  in  1  asynchronous, active-high reset
- req_0 / req_1  in  1  request; held high with its fields stable until the matching ack
- wr_0 / wr_1  in  1  1 = write, 0 = read
- addr_0 / addr_1  in  20  byte address
- wdata_0 / wdata_1  in  8  write data
- ack_0 / ack_1  out  1  one-cycle completion pulse
- rdata  out  8  read data; valid in the ack cycle, held until the next ack
- ack_err  out  1  pulses with ack when the address was out of range
- busy  out  1  high in every state except IDLE
- ram_addr  out  20  to RAM addr_b
- ram_wdata  out  8  to RAM data_in_b
- ram_we  out  1  to RAM wr_en_b
- ram_rdata  in  8  from RAM data_out_b

## Operation
- State machine states: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request pending: stay in IDLE.
- IDLE, any req high:
  - pick the winner;
  - latch its wr, addr and wdata;
  - load ram_addr and ram_wdata;
  - set ram_we = wr AND in_range;
  - go to ISSUE.
- ISSUE (1 cycle):
  - ram_we is high only in this state;
  - write: go to DONE;
  - read: load the wait counter with RAM_LAT-1 and go to WAIT.
- WAIT:
  - counter not zero: decrement;
  - counter zero: capture rdata (ram_rdata if in range, otherwise 8'hFF) and go to DONE.
- DONE:
  - pulse the winner's ack;
  - pulse ack_err if out of range;
  - clear ram_we and go to IDLE.
- Out-of-range write: no RAM write occurs. The handshake timing is unchanged and ack_err is asserted.
- Handshake rule: the requester drops req on the clock edge where it samples ack high. A req still high in the following IDLE cycle is treated as a new request.
- Both req high in IDLE: the arbitration policy (see Configuration) picks the winner. The loser stays pending and is served next.
- A req that rises while the arbiter is busy waits. It is not lost.
- Reset mid-transaction:
  - the transaction is abandoned and no ack is issued;
  - the state returns to IDLE at once;
  - ram_we is forced low asynchronously.
- Reset values: ram_addr 0, ram_wdata 0, ram_we 0, ack_0 0, ack_1 0, ack_err 0, rdata 0, busy 0, state IDLE, priority pointer favouring requester 0.

## Timing
- Edge E0: req is sampled in IDLE.
- Write: ram_we is high in the cycle after E0. Ack is high in the cycle after that, i.e. 2 cycles after E0.
- Read: ack is high RAM_LAT+2 cycles after E0. With the default RAM_LAT=2, ack comes 4 cycles after E0.
- Back-to-back throughput: one write every 3 cycles, one read every RAM_LAT+3 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: GPU_HOST_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The requester that most recently won gets lower priority on the next simultaneous request.
  - The pointer updates only on the IDLE-to-ISSUE transition.
- Undefined: fixed priority; requester 0 (the host) always wins. The pointer logic is not built.

## Structure
- Shared package gpu_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - requester index constants REQ_HOST=0 and REQ_GEO=1;
  - the 8'hFF out-of-range read value.
- One sub-module, gpu_arb_pick2, is natural. It is a combinational 2-way picker that takes req_0, req_1 and the pointer and returns a winner index plus a valid flag. The macro selects its policy.

## Test plan
- Single write: req_0, wr=1, addr 0x00123, wdata 0xA5 -> ram_we high for exactly 1 cycle with ram_addr 0x00123 and ram_wdata 0xA5; ack_0 pulses 2 cycles after E0.
- Single read: RAM model holds 0x3C at 0x00040; req_1 read of 0x00040 -> rdata 0x3C with ack_1 exactly RAM_LAT+2 cycles after E0; ack_err 0.
- Out of range: write to 0x04000 with ADDR_SIZE=14 -> ram_we stays 0 and ack_err pulses with ack. A read of 0x04000 returns 0xFF.
- Contention: req_0 and req_1 high in the same cycle and held through repeated transactions.
  - Round robin: grants alternate 0, 1, 0, 1.
  - Fixed priority: requester 0 is served first; requester 1 is served when req_0 drops.
- Reset during WAIT: assert rst mid-read -> ram_we 0 immediately, no ack issued, state IDLE. A new write after reset completes with normal timing.
